hazard_ctrl: RTL and testbench



---
 rtl/dlx_pkg.sv | 12 +
 rtl/hazard_cmp.sv | 17 +
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX core definitions: register-specifier width and hazard scheduler FSM states.
package dlx_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_HOLD  = 2'd1,
    BR_RESOLVE = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Per-operand load-use comparator: flags a read of the register an EX-stage load is writing.
module hazard_cmp
  import dlx_pkg::*;
#(
  parameter int REG_W = dlx_pkg::REG_W
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  logic [REG_W-1:0] dst_i,
  input  logic             mem_read_i,
  output logic             hit_o
);

  // r0 is hardwired to zero, so a zero destination never creates a dependency.
  assign hit_o = mem_read_i & (dst_i != '0) & use_i & (src_i == dst_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch hazard scheduler for the 5-stage DLX pipeline.
// Optional statistics counters are built when HAZARD_CTRL_STATS_EN is defined.
module hazard_ctrl
  import dlx_pkg::*;
#(
  parameter int REG_W = dlx_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             branch_id,
  input  logic [REG_W-1:0] towrite_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             pc_take_branch,
  output logic             lw_stall_ex,
  output logic             Branch_stall_forwarding,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  hz_state_e state_q, state_d;
  logic      hit_rs, hit_rt, luh;
  logic      lw_stall_q, bsf_q;

  hazard_cmp #(.REG_W(REG_W)) u_cmp_rs (
    .src_i      (rs_id),
    .use_i      (use_rs_id),
    .dst_i      (towrite_ex),
    .mem_read_i (mem_read_ex),
    .hit_o      (hit_rs)
  );

  hazard_cmp #(.REG_W(REG_W)) u_cmp_rt (
    .src_i      (rt_id),
    .use_i      (use_rt_id),
    .dst_i      (towrite_ex),
    .mem_read_i (mem_read_ex),
    .hit_o      (hit_rt)
  );

  assign luh = hit_rs | hit_rt;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Mealy decode; held quiet during reset so a pending branch redirect is dropped.
  always_comb begin
    state_d        = state_q;
    stall_pc       = 1'b0;
    stall_ifid     = 1'b0;
    flush_ifid     = 1'b0;
    bubble_idex    = 1'b0;
    pc_take_branch = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (luh) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
            state_d     = LOAD_HOLD;
          end else if (branch_id) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
            state_d    = BR_RESOLVE;
          end
        end
        LOAD_HOLD: begin
          if (branch_id) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
            state_d    = BR_RESOLVE;
          end else begin
            state_d = RUN;
          end
        end
        BR_RESOLVE: begin
          pc_take_branch = branch_taken_ex;
          state_d        = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lw_stall_q <= 1'b0;
      bsf_q      <= 1'b0;
    end else begin
      lw_stall_q <= (state_q == LOAD_HOLD);
      bsf_q      <= bubble_idex | flush_ifid;
    end
  end

  assign lw_stall_ex             = lw_stall_q;
  assign Branch_stall_forwarding = bsf_q;

`ifdef HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, taken_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (stall_pc) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (pc_take_branch) taken_cnt_q <= sat_inc(taken_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign stall_cnt = '0;
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; stats checks follow HAZARD_CTRL_STATS_EN.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_id, rt_id, towrite_ex;
  logic        use_rs_id, use_rt_id, branch_id, mem_read_ex, branch_taken_ex;
  logic        stall_pc, stall_ifid, flush_ifid, bubble_idex, pc_take_branch;
  logic        lw_stall_ex, Branch_stall_forwarding;
  logic [15:0] stall_cnt, taken_cnt;
  logic [6:0]  outv;
  int          errors = 0;
  int          checks = 0;

  hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .rs_id                   (rs_id),
    .rt_id                   (rt_id),
    .use_rs_id               (use_rs_id),
    .use_rt_id               (use_rt_id),
    .branch_id               (branch_id),
    .towrite_ex              (towrite_ex),
    .mem_read_ex             (mem_read_ex),
    .branch_taken_ex         (branch_taken_ex),
    .stall_pc                (stall_pc),
    .stall_ifid              (stall_ifid),
    .flush_ifid              (flush_ifid),
    .bubble_idex             (bubble_idex),
    .pc_take_branch          (pc_take_branch),
    .lw_stall_ex             (lw_stall_ex),
    .Branch_stall_forwarding (Branch_stall_forwarding),
    .stall_cnt               (stall_cnt),
    .taken_cnt               (taken_cnt)
  );

  // {stall_pc, stall_ifid, flush_ifid, bubble_idex, pc_take_branch, lw_stall_ex, Branch_stall_forwarding}
  assign outv = {stall_pc, stall_ifid, flush_ifid, bubble_idex,
                 pc_take_branch, lw_stall_ex, Branch_stall_forwarding};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; towrite_ex = 5'd0;
    use_rs_id = 1'b0; use_rt_id = 1'b0; branch_id = 1'b0;
    mem_read_ex = 1'b0; branch_taken_ex = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic set_luh();
    mem_read_ex = 1'b1; towrite_ex = 5'd5; rs_id = 5'd5; use_rs_id = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_out", {9'd0, outv}, 16'h0000);
    chk("reset_stall_cnt", stall_cnt, 16'h0000);
    chk("reset_taken_cnt", taken_cnt, 16'h0000);

    // Load-use on rs
    cyc(); set_luh();              #1 chk("lu_t",   {9'd0, outv}, 16'b1101000);
    cyc(); set_luh();              #1 chk("lu_t1",  {9'd0, outv}, 16'b0000001);
    cyc();                         #1 chk("lu_t2",  {9'd0, outv}, 16'b0000010);
    cyc();                         #1 chk("lu_t3",  {9'd0, outv}, 16'b0000000);

    // Zero destination and unused operand never stall
    cyc(); mem_read_ex = 1'b1; use_rs_id = 1'b1;
                                   #1 chk("zero_dst", {9'd0, outv}, 16'b0000000);
    cyc();                         #1 chk("zero_nlw", {9'd0, outv}, 16'b0000000);
    cyc(); mem_read_ex = 1'b1; towrite_ex = 5'd9; rs_id = 5'd9;
                                   #1 chk("no_use",   {9'd0, outv}, 16'b0000000);
    cyc(); towrite_ex = 5'd9; rs_id = 5'd9; use_rs_id = 1'b1;
                                   #1 chk("not_load", {9'd0, outv}, 16'b0000000);

    // Load-use on rt
    cyc(); mem_read_ex = 1'b1; towrite_ex = 5'd7; rt_id = 5'd7; use_rt_id = 1'b1;
                                   #1 chk("rt_t",   {9'd0, outv}, 16'b1101000);
    cyc();                         #1 chk("rt_t1",  {9'd0, outv}, 16'b0000001);
    cyc();                         #1 chk("rt_t2",  {9'd0, outv}, 16'b0000010);

    // Branch taken
    cyc(); branch_id = 1'b1;       #1 chk("bt_t",   {9'd0, outv}, 16'b1010000);
    cyc(); branch_taken_ex = 1'b1; #1 chk("bt_t1",  {9'd0, outv}, 16'b0000101);
    cyc();                         #1 chk("bt_t2",  {9'd0, outv}, 16'b0000000);

    // Branch untaken, then load-use in the very next RUN cycle
    cyc(); branch_id = 1'b1;       #1 chk("bn_t",   {9'd0, outv}, 16'b1010000);
    cyc(); set_luh();              #1 chk("bn_t1",  {9'd0, outv}, 16'b0000001);
    cyc(); set_luh();              #1 chk("b2b_lu", {9'd0, outv}, 16'b1101000);
    cyc();                         #1 chk("b2b_t1", {9'd0, outv}, 16'b0000001);
    cyc();                         #1 chk("b2b_t2", {9'd0, outv}, 16'b0000010);

    // Load feeding a branch: luh wins, branch handled from LOAD_HOLD
    cyc(); set_luh(); branch_id = 1'b1;
                                   #1 chk("lb_t",   {9'd0, outv}, 16'b1101000);
    cyc(); set_luh(); branch_id = 1'b1;
                                   #1 chk("lb_t1",  {9'd0, outv}, 16'b1010001);
    cyc(); branch_taken_ex = 1'b1; #1 chk("lb_t2",  {9'd0, outv}, 16'b0000111);
    cyc();                         #1 chk("lb_t3",  {9'd0, outv}, 16'b0000000);

    // Reset during BR_RESOLVE drops the redirect
    cyc(); branch_id = 1'b1;       #1 chk("rb_t",   {9'd0, outv}, 16'b1010000);
    cyc(); reset = 1'b1; branch_taken_ex = 1'b1;
                                   #1 chk("rb_ptb", {15'd0, pc_take_branch}, 16'h0000);
    cyc(); reset = 1'b0;           #1 chk("rb_out", {9'd0, outv}, 16'b0000000);
    cyc(); set_luh();              #1 chk("rb_run", {9'd0, outv}, 16'b1101000);

    // Reset during LOAD_HOLD drops lw_stall_ex
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;           #1 chk("rl_out", {9'd0, outv}, 16'b0000000);
    cyc();                         #1 chk("rl_nlw", {9'd0, outv}, 16'b0000000);
    chk("rl_stall_cnt", stall_cnt, 16'h0000);

    // Statistics: 3 load-use stalls, 2 taken branches
    for (int i = 0; i < 3; i++) begin
      cyc(); set_luh();
      cyc();
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); branch_id = 1'b1;
      cyc(); branch_taken_ex = 1'b1;
    end
    cyc();
`ifdef HAZARD_CTRL_STATS_EN
    #1 chk("stall_cnt", stall_cnt, 16'd5);
    chk("taken_cnt", taken_cnt, 16'd2);
    cyc();
    force dut.stall_cnt_q = 16'hFFFF;
    #1 release dut.stall_cnt_q;
    set_luh();
    cyc();                         #1 chk("stall_sat", stall_cnt, 16'hFFFF);
`else
    #1 chk("stall_cnt_off", stall_cnt, 16'h0000);
    chk("taken_cnt_off", taken_cnt, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
